pc_ctrl: RTL and testbench

Next-PC sequencer for the fetch stage. It drives the pc_reg control pair (ctrl, pc_i), and pc_reg increments by 1 (word address) whenever ctrl is low. pc_ctrl arbitrates redirect requests from the trap unit, mret and execute-stage branches/jumps. It holds the PC during stalls or when instruction memory is not ready, parks a redirect that cannot be applied yet, and generates the IF/ID flush.

---
 rtl/pc_ctrl_pkg.sv | 45 ++++
 rtl/pc_ctrl_redir_arb.sv | 40 ++++
 rtl/pc_ctrl.sv | 147 ++++++++++++++
 tb/tb_pc_ctrl.sv | 217 +++++++++++++++++++++
 4 files changed

// File: rtl/pc_ctrl_pkg.sv
// rtl/pc_ctrl_pkg.sv - shared types for the fetch-stage next-PC sequencer
//
// Purpose: instruction-address bus type, sequencer state encoding, redirect
// priority encoding, the redirect descriptor struct and the default boot
// address define.
// Ports: none (package).

`ifndef CpuResetAddr
`define CpuResetAddr 32'h0000_0000
`endif

package pc_ctrl_pkg;

    localparam int InstAddrWidth = 32;

    typedef logic [InstAddrWidth-1:0] InstAddrBus;

    typedef enum logic [1:0] {
        BOOT = 2'd0,
        RUN  = 2'd1,
        PEND = 2'd2
    } pc_state_e;

    // PRIO_NONE only marks an empty descriptor; real requests rank 1..3.
    typedef enum logic [1:0] {
        PRIO_NONE = 2'd0,
        PRIO_BR   = 2'd1,
        PRIO_MRET = 2'd2,
        PRIO_TRAP = 2'd3
    } redir_prio_e;

    typedef struct packed {
        logic        vld;
        redir_prio_e prio;
        InstAddrBus  tgt;
    } redir_t;

    localparam redir_t RedirNone = '{vld: 1'b0, prio: PRIO_NONE, tgt: '0};

    // A new request replaces a parked one when it ranks equal or higher.
    function automatic logic redir_overrides(input redir_t new_r, input redir_t old_r);
        return new_r.vld && (!old_r.vld || (new_r.prio >= old_r.prio));
    endfunction

endpackage

// File: rtl/pc_ctrl_redir_arb.sv
// rtl/pc_ctrl_redir_arb.sv - priority select of trap/mret/branch redirects
//
// Purpose: combinational pick of the highest-priority incoming redirect
// (trap > mret > branch) and the merge of that pick with the parked entry.
// Ports:
//   trap_req_i/trap_vec_i  trap request and vector
//   mret_req_i/mepc_i      mret request and return address
//   br_req_i/br_tgt_i      branch/jump request and target
//   pend_i                 currently parked redirect
//   req_o                  winning incoming request (vld=0 if none)
//   win_o                  req_o if it overrides pend_i, else pend_i

module pc_ctrl_redir_arb
    import pc_ctrl_pkg::*;
(
    input  logic       trap_req_i,
    input  InstAddrBus trap_vec_i,
    input  logic       mret_req_i,
    input  InstAddrBus mepc_i,
    input  logic       br_req_i,
    input  InstAddrBus br_tgt_i,
    input  redir_t     pend_i,
    output redir_t     req_o,
    output redir_t     win_o
);

    always_comb begin
        req_o = RedirNone;
        if (trap_req_i) begin
            req_o = '{vld: 1'b1, prio: PRIO_TRAP, tgt: trap_vec_i};
        end else if (mret_req_i) begin
            req_o = '{vld: 1'b1, prio: PRIO_MRET, tgt: mepc_i};
        end else if (br_req_i) begin
            req_o = '{vld: 1'b1, prio: PRIO_BR, tgt: br_tgt_i};
        end

        win_o = redir_overrides(req_o, pend_i) ? req_o : pend_i;
    end

endmodule

// File: rtl/pc_ctrl.sv
// rtl/pc_ctrl.sv - next-PC sequencer driving the pc_reg control pair
//
// Purpose: arbitrates trap/mret/branch redirects, holds the PC during stalls
// or when imem is not ready, parks redirects that cannot be applied yet and
// generates the IF/ID flush.
// Ports:
//   clk, rst_n          clock, synchronous active-low reset
//   pc_cur_i            current PC from pc_reg
//   stall_i             hazard stall
//   imem_ready_i        imem accepts the fetch this cycle
//   br_req_i/br_tgt_i   branch/jump pulse and target
//   trap_req_i/trap_vec_i trap pulse and vector
//   mret_req_i/mepc_i   mret pulse and return address
//   ctrl_o              1 = pc_reg loads pc_next_o, 0 = pc_reg increments
//   pc_next_o           load value for pc_reg
//   fetch_valid_o       fetch request valid toward imem
//   flush_o             kill IF/ID contents

module pc_ctrl
    import pc_ctrl_pkg::*;
#(
    parameter InstAddrBus RESET_ADDR   = `CpuResetAddr,
    parameter int         FLUSH_CYCLES = 2
) (
    input  logic       clk,
    input  logic       rst_n,
    input  InstAddrBus pc_cur_i,
    input  logic       stall_i,
    input  logic       imem_ready_i,
    input  logic       br_req_i,
    input  InstAddrBus br_tgt_i,
    input  logic       trap_req_i,
    input  InstAddrBus trap_vec_i,
    input  logic       mret_req_i,
    input  InstAddrBus mepc_i,
    output logic       ctrl_o,
    output InstAddrBus pc_next_o,
    output logic       fetch_valid_o,
    output logic       flush_o
);

    // The apply cycle itself is one of the FLUSH_CYCLES flush cycles.
    localparam logic [2:0] FlushLoad = 3'(FLUSH_CYCLES - 1);

    pc_state_e  state_q, state_d;
    redir_t     pend_q, pend_d;
    logic [2:0] cnt_q, cnt_d;

    redir_t req;
    redir_t win;
    logic   adv;
    logic   ready_go;
    logic   apply;
    logic   hold_flush;

    pc_ctrl_redir_arb u_arb (
        .trap_req_i (trap_req_i),
        .trap_vec_i (trap_vec_i),
        .mret_req_i (mret_req_i),
        .mepc_i     (mepc_i),
        .br_req_i   (br_req_i),
        .br_tgt_i   (br_tgt_i),
        .pend_i     (pend_q),
        .req_o      (req),
        .win_o      (win)
    );

    assign ready_go = !stall_i && imem_ready_i;
    assign adv      = (state_q == RUN) && ready_go;

    always_comb begin
        state_d       = state_q;
        pend_d        = pend_q;
        cnt_d         = (cnt_q != 3'd0) ? (cnt_q - 3'd1) : 3'd0;
        ctrl_o        = 1'b1;
        pc_next_o     = pc_cur_i;
        fetch_valid_o = 1'b0;
        apply         = 1'b0;
        hold_flush    = 1'b0;

        case (state_q)
            BOOT: begin
                hold_flush = 1'b1;
                state_d    = RUN;
                // A pulse seen during BOOT would otherwise be lost.
                if (req.vld) begin
                    pend_d  = req;
                    state_d = PEND;
                end
            end

            RUN: begin
                fetch_valid_o = !stall_i;
                if (req.vld) begin
                    if (adv) begin
                        pc_next_o = req.tgt;
                        apply     = 1'b1;
                    end else begin
                        pend_d  = req;
                        state_d = PEND;
                    end
                end else if (adv) begin
                    ctrl_o = 1'b0;
                end
            end

            PEND: begin
                hold_flush = 1'b1;
                pend_d     = win;
                if (ready_go) begin
                    pc_next_o = win.tgt;
                    apply     = 1'b1;
                    pend_d    = RedirNone;
                    state_d   = RUN;
                end
            end

            default: begin
                state_d = BOOT;
                pend_d  = RedirNone;
            end
        endcase

        if (apply) begin
            cnt_d = FlushLoad;
        end

        flush_o = apply || hold_flush || (cnt_q != 3'd0);

        if (!rst_n) begin
            ctrl_o        = 1'b1;
            pc_next_o     = RESET_ADDR;
            fetch_valid_o = 1'b0;
            flush_o       = 1'b1;
            state_d       = BOOT;
            pend_d        = RedirNone;
            cnt_d         = 3'd0;
        end
    end

    always_ff @(posedge clk) begin
        state_q <= state_d;
        pend_q  <= pend_d;
        cnt_q   <= cnt_d;
    end

endmodule

// File: tb/tb_pc_ctrl.sv
// tb/tb_pc_ctrl.sv - self-checking bench for pc_ctrl with a pc_reg model

module tb_pc_ctrl;

    localparam logic [31:0] RA = 32'h0000_0000;
    localparam int          FC = 2;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [31:0] pc_cur;
    logic        stall = 1'b0, ready = 1'b1;
    logic        br = 1'b0, trap = 1'b0, mret = 1'b0;
    logic [31:0] bt = '0, tv = '0, mv = '0;
    logic        ctrl_o, fetch_valid_o, flush_o;
    logic [31:0] pc_next_o;

    int checks = 0;
    int errors = 0;
    int hits80 = 0;

    always #5 clk = ~clk;

    pc_ctrl #(.RESET_ADDR(RA), .FLUSH_CYCLES(FC)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .pc_cur_i      (pc_cur),
        .stall_i       (stall),
        .imem_ready_i  (ready),
        .br_req_i      (br),
        .br_tgt_i      (bt),
        .trap_req_i    (trap),
        .trap_vec_i    (tv),
        .mret_req_i    (mret),
        .mepc_i        (mv),
        .ctrl_o        (ctrl_o),
        .pc_next_o     (pc_next_o),
        .fetch_valid_o (fetch_valid_o),
        .flush_o       (flush_o)
    );

    // pc_reg environment: load on ctrl, otherwise increment.
    initial pc_cur = 32'hDEAD_0000;
    always @(posedge clk) pc_cur <= ctrl_o ? pc_next_o : pc_cur + 32'd1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Behavioural model: booting flag, parked redirect (rank/target),
    // remaining flush cycles after the apply cycle.
    bit          m_boot = 1'b1;
    bit          m_park = 1'b0;
    int          m_prank = 0;
    logic [31:0] m_ptgt = '0;
    int          m_flush = 0;

    always @(negedge clk) begin
        int          nrank;
        logic [31:0] ntgt;
        bit          go, applied;
        logic        e_ctrl, e_fv, e_fl;
        logic [31:0] e_next;
        nrank = trap ? 3 : mret ? 2 : br ? 1 : 0;
        ntgt  = trap ? tv : mret ? mv : bt;
        go    = !stall && ready;
        applied = 1'b0;
        if (!rst_n) begin
            e_ctrl = 1'b1; e_next = RA; e_fv = 1'b0; e_fl = 1'b1;
            m_boot = 1'b1; m_park = 1'b0; m_flush = 0;
        end else begin
            e_ctrl = 1'b1; e_next = pc_cur; e_fv = 1'b0; e_fl = 1'b0;
            if (m_boot) begin
                e_fl = 1'b1;
                m_boot = 1'b0;
                if (nrank > 0) begin
                    m_park = 1'b1; m_prank = nrank; m_ptgt = ntgt;
                end
            end else if (m_park) begin
                e_fl = 1'b1;
                if (nrank > 0 && nrank >= m_prank) begin
                    m_prank = nrank; m_ptgt = ntgt;
                end
                if (go) begin
                    e_next = m_ptgt; applied = 1'b1; m_park = 1'b0;
                end
            end else begin
                e_fv = !stall;
                if (nrank > 0) begin
                    if (go) begin
                        e_next = ntgt; applied = 1'b1;
                    end else begin
                        m_park = 1'b1; m_prank = nrank; m_ptgt = ntgt;
                    end
                end else if (go) begin
                    e_ctrl = 1'b0;
                end
            end
            if (applied || m_flush > 0) e_fl = 1'b1;
            m_flush = applied ? FC - 1 : (m_flush > 0 ? m_flush - 1 : 0);
        end
        chk("m_ctrl", 32'(ctrl_o), 32'(e_ctrl));
        if (e_ctrl) chk("m_pc_next", pc_next_o, e_next);
        chk("m_fetch_valid", 32'(fetch_valid_o), 32'(e_fv));
        chk("m_flush", 32'(flush_o), 32'(e_fl));
        if (rst_n && ctrl_o && pc_next_o == 32'h80 && pc_cur != 32'h80) hits80++;
    end

    // Drive one cycle of inputs just after the edge, return at the negedge.
    task automatic cyc(input bit r, input bit s, input bit rd,
                       input bit b, input logic [31:0] btv,
                       input bit t, input logic [31:0] tvv,
                       input bit m, input logic [31:0] mvv);
        @(posedge clk);
        #1;
        rst_n = r; stall = s; ready = rd;
        br = b; bt = btv; trap = t; tv = tvv; mret = m; mv = mvv;
        @(negedge clk);
    endtask

    task automatic idle();
        cyc(1, 0, 1, 0, 0, 0, 0, 0, 0);
    endtask

    initial begin
        // Reset held 3 cycles.
        for (int i = 0; i < 3; i++) begin
            cyc(0, 0, 1, 0, 0, 0, 0, 0, 0);
            chk("rst_ctrl", 32'(ctrl_o), 32'd1);
            chk("rst_pc_next", pc_next_o, 32'h0);
            chk("rst_flush", 32'(flush_o), 32'd1);
        end
        // BOOT hold cycle.
        idle();
        chk("boot_fetch_valid", 32'(fetch_valid_o), 32'd0);
        chk("boot_pc_next", pc_next_o, 32'h0);
        // Increment sequence 0,1,2,3.
        for (int i = 0; i < 4; i++) begin
            idle();
            chk("run_ctrl", 32'(ctrl_o), 32'd0);
            chk("run_pc_seq", pc_cur, 32'(i));
        end
        // Run up to 0x0F so that the stalled cycles see PC=0x10.
        for (int i = 0; i < 40 && pc_cur != 32'h0F; i++) idle();
        chk("reach_0x0f", pc_cur, 32'h0F);
        for (int i = 0; i < 2; i++) begin
            cyc(1, 1, 1, 0, 0, 0, 0, 0, 0);
            chk("stall_ctrl", 32'(ctrl_o), 32'd1);
            chk("stall_pc_next", pc_next_o, 32'h10);
            chk("stall_fetch_valid", 32'(fetch_valid_o), 32'd0);
        end
        idle();
        chk("resume_pc", pc_cur, 32'h10);
        idle();
        chk("resume_pc_inc", pc_cur, 32'h11);

        // Same-cycle branch, two flush cycles.
        cyc(1, 0, 1, 1, 32'h80, 0, 0, 0, 0);
        chk("br_ctrl", 32'(ctrl_o), 32'd1);
        chk("br_pc_next", pc_next_o, 32'h80);
        chk("br_flush0", 32'(flush_o), 32'd1);
        idle();
        chk("br_flush1", 32'(flush_o), 32'd1);
        chk("br_pc_loaded", pc_cur, 32'h80);
        idle();
        chk("br_flush2", 32'(flush_o), 32'd0);

        // Parked branch overwritten by a trap.
        hits80 = 0;
        cyc(1, 0, 0, 1, 32'h80, 0, 0, 0, 0);
        chk("park_hold", pc_next_o, pc_cur);
        cyc(1, 0, 0, 0, 0, 1, 32'h200, 0, 0);
        chk("pend_flush", 32'(flush_o), 32'd1);
        chk("pend_fetch_valid", 32'(fetch_valid_o), 32'd0);
        cyc(1, 0, 0, 0, 0, 0, 0, 0, 0);
        cyc(1, 0, 0, 0, 0, 0, 0, 0, 0);
        cyc(1, 0, 1, 0, 0, 0, 0, 0, 0);
        chk("pend_apply_pc", pc_next_o, 32'h200);
        chk("pend_apply_ctrl", 32'(ctrl_o), 32'd1);
        idle();
        chk("pend_post_flush", 32'(flush_o), 32'd1);
        idle();
        chk("pend_flush_done", 32'(flush_o), 32'd0);
        chk("no_0x80_applied", 32'(hits80), 32'd0);

        // Simultaneous requests, then mret alone.
        cyc(1, 0, 1, 1, 32'h80, 1, 32'h200, 1, 32'h40);
        chk("all3_pc_next", pc_next_o, 32'h200);
        cyc(1, 0, 1, 0, 0, 0, 0, 1, 32'h40);
        chk("mret_pc_next", pc_next_o, 32'h40);
        idle();
        chk("mret_pc_loaded", pc_cur, 32'h40);
        idle();

        // Reset while a branch is parked.
        hits80 = 0;
        cyc(1, 0, 0, 1, 32'h80, 0, 0, 0, 0);
        cyc(0, 0, 0, 0, 0, 0, 0, 0, 0);
        chk("midrst_pc_next", pc_next_o, RA);
        chk("midrst_ctrl", 32'(ctrl_o), 32'd1);
        idle();
        chk("midrst_boot_fv", 32'(fetch_valid_o), 32'd0);
        chk("midrst_boot_hold", pc_next_o, 32'h0);
        idle();
        chk("midrst_flush_clear", 32'(flush_o), 32'd0);
        chk("midrst_run_ctrl", 32'(ctrl_o), 32'd0);
        idle();
        chk("midrst_no_0x80", 32'(hits80), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
